calc_ctrl: RTL

CALC_CTRL -- requirements
Module: calc_ctrl

---
 rtl/calc_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/calc_ctrl.sv
// calc_ctrl: keypad-driven control FSM for a two-operand decimal calculator
// sharing an external ALU.
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   key_valid, key_code  - keypad strobe and code (0-9 digit, 10 ADD, 11 SUB,
//                          12 MUL, 13 EQ, 14 CLR, 15 no-op)
//   key_ready            - non-CLR keys accepted (low only while the ALU is busy)
//   alu_start, alu_op,
//   alu_a, alu_b         - ALU request pulse and operands
//   alu_done, alu_result - ALU completion pulse and two's-complement result
//   disp_val, disp_op    - value and operator for the display
//   err                  - ALU timeout error indicator
//   state                - current FSM state
module calc_ctrl #(
   parameter int unsigned MAXDIG  = 2,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic        key_ready,
   output logic        alu_start,
   output logic [1:0]  alu_op,
   output logic [6:0]  alu_a,
   output logic [6:0]  alu_b,
   input  logic        alu_done,
   input  logic [14:0] alu_result,
   output logic [14:0] disp_val,
   output logic [1:0]  disp_op,
   output logic        err,
   output logic [2:0]  state
);

   localparam int unsigned OPND_W = 7;
   localparam int unsigned CNT_W  = 2;
   localparam int unsigned TMO_W  = 8;
   localparam int unsigned DISP_W = 15;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAXDIG);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT);

   typedef enum logic [2:0] {
      ST_ENTER_A = 3'd0,
      ST_OP_WAIT = 3'd1,
      ST_ENTER_B = 3'd2,
      ST_EXEC    = 3'd3,
      ST_SHOW    = 3'd4,
      ST_ERR     = 3'd5
   } state_t;

   state_t              state_reg, state_nxt;
   logic [OPND_W-1:0]   a_reg, a_nxt, b_reg, b_nxt;
   logic [CNT_W-1:0]    cnt_reg, cnt_nxt;
   logic [1:0]          op_reg, op_nxt;
   logic [TMO_W-1:0]    tmo_reg, tmo_nxt;
   logic [DISP_W-1:0]   disp_nxt;
   logic                start_nxt, ready_nxt, err_nxt;

   // Key decode: CLR bypasses key_ready, everything else needs it
   logic key_acc, key_clr, key_dig, key_op, key_eq;
   assign key_acc = key_valid && key_ready;
   assign key_clr = key_valid && (key_code == 4'd14);
   assign key_dig = key_acc && (key_code <= 4'd9);
   assign key_op  = key_acc && (key_code >= 4'd10) && (key_code <= 4'd12);
   assign key_eq  = key_acc && (key_code == 4'd13);

   assign state   = state_reg;
   assign alu_a   = a_reg;
   assign alu_b   = b_reg;
   assign alu_op  = op_reg;
   assign disp_op = op_reg;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= ST_ENTER_A;
      else       state_reg <= state_nxt;
   end

   // Next-state logic; CLR overrides everything, including a same-cycle alu_done
   always_comb begin
      state_nxt = state_reg;
      if (key_clr) begin
         state_nxt = ST_ENTER_A;
      end else begin
         case (state_reg)
            ST_ENTER_A: if (key_op)  state_nxt = ST_OP_WAIT;
            ST_OP_WAIT: if (key_dig) state_nxt = ST_ENTER_B;
            ST_ENTER_B: if (key_eq)  state_nxt = ST_EXEC;
            // alu_done wins over a timeout expiring in the same cycle
            ST_EXEC: begin
               if (alu_done)                   state_nxt = ST_SHOW;
               else if (tmo_reg <= TMO_W'(1))  state_nxt = ST_ERR;
            end
            ST_SHOW:    if (key_dig) state_nxt = ST_ENTER_A;
            default:    state_nxt = state_reg;
         endcase
      end
   end

   // Output / datapath next values
   always_comb begin
      a_nxt     = a_reg;
      b_nxt     = b_reg;
      cnt_nxt   = cnt_reg;
      op_nxt    = op_reg;
      tmo_nxt   = tmo_reg;
      start_nxt = 1'b0;
      if (key_clr) begin
         a_nxt   = '0;
         b_nxt   = '0;
         cnt_nxt = '0;
         op_nxt  = '0;
         tmo_nxt = '0;
      end else begin
         case (state_reg)
            ST_ENTER_A: begin
               // Digits beyond MAXDIG are dropped rather than wrapping
               if (key_dig && (cnt_reg < CNT_MAX)) begin
                  a_nxt   = OPND_W'(a_reg * OPND_W'(10) + OPND_W'(key_code));
                  cnt_nxt = cnt_reg + CNT_W'(1);
               end else if (key_op) begin
                  op_nxt  = 2'(key_code - 4'd10);
                  cnt_nxt = '0;
               end
            end
            ST_OP_WAIT: begin
               if (key_op) begin
                  op_nxt = 2'(key_code - 4'd10);
               end else if (key_dig) begin
                  b_nxt   = OPND_W'(key_code);
                  cnt_nxt = CNT_W'(1);
               end
            end
            ST_ENTER_B: begin
               if (key_dig && (cnt_reg < CNT_MAX)) begin
                  b_nxt   = OPND_W'(b_reg * OPND_W'(10) + OPND_W'(key_code));
                  cnt_nxt = cnt_reg + CNT_W'(1);
               end else if (key_eq) begin
                  start_nxt = 1'b1;
                  tmo_nxt   = TMO_LOAD;
               end
            end
            ST_EXEC: begin
               if (!alu_done && (tmo_reg != '0)) tmo_nxt = tmo_reg - TMO_W'(1);
            end
            ST_SHOW: begin
               if (key_dig) begin
                  a_nxt   = OPND_W'(key_code);
                  b_nxt   = '0;
                  cnt_nxt = CNT_W'(1);
               end
            end
            default: ;
         endcase
      end

      // Display follows the state being entered
      case (state_nxt)
         ST_ENTER_A, ST_OP_WAIT: disp_nxt = DISP_W'(a_nxt);
         ST_ENTER_B, ST_EXEC:    disp_nxt = DISP_W'(b_nxt);
         ST_SHOW:                disp_nxt = (state_reg == ST_EXEC) ? alu_result : disp_val;
         default:                disp_nxt = '0;
      endcase
      ready_nxt = (state_nxt != ST_EXEC);
      err_nxt   = (state_nxt == ST_ERR);
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_reg     <= '0;
         b_reg     <= '0;
         cnt_reg   <= '0;
         op_reg    <= '0;
         tmo_reg   <= '0;
         disp_val  <= '0;
         alu_start <= 1'b0;
         key_ready <= 1'b1;
         err       <= 1'b0;
      end else begin
         a_reg     <= a_nxt;
         b_reg     <= b_nxt;
         cnt_reg   <= cnt_nxt;
         op_reg    <= op_nxt;
         tmo_reg   <= tmo_nxt;
         disp_val  <= disp_nxt;
         alu_start <= start_nxt;
         key_ready <= ready_nxt;
         err       <= err_nxt;
      end
   end

endmodule
